fta_split128to32: RTL and testbench
===================================

// Module: fta_split128to32
// PURPOSE
//  Sequential 128->32 FTA bus adapter in front of 32-bit slaves. Takes one 128-bit request,
//  issues one 32-bit beat per non-empty sel nibble (ascending lane order) and merges the beat
//  responses into a single 128-bit response. It carries the octa/hexi and multi-lane accesses
//  that the combinational 128->32 bridge flags with szerr.
// PARAMETERS
//  TIMEOUT    1023  cycles a beat may wait for ack/err/rty before it is treated as err
//  MAX_RETRY  3     rty responses per beat before the transaction is failed with err
// PORTS
//  clk_i      in   1                      clock
//  rst_i      in   1                      synchronous, active-high reset
//  req128_i   in   fta_cmd_request128_t   upstream request (cyc/stb/we/sel[15:0]/padr/data1)
//  resp128_o  out  fta_cmd_response128_t  upstream response
//  req32_o    out  fta_cmd_request32_t    downstream beat request
//  resp32_i   in   fta_cmd_response32_t   downstream beat response
//  busy_o     out  1                      transaction in progress (state != IDLE)
// BEHAVIOUR
//  Clock/reset: one clock (clk_i); rst_i is synchronous and active-high.
//  Reset: state=IDLE; req32_o all-zero (cyc=stb=we=0, sel=0); resp128_o all-zero (ack=err=rty=stall=0);
//   busy_o=0; retry/timeout counters=0.
//  Upstream handshake: resp128_o.stall = (state!=IDLE). A request is accepted only in IDLE when
//   cyc&stb. On acceptance the whole request is latched, along with lane mask m[i] = |sel[4i+3:4i].
//   Upstream must hold off until it sees ack/err for the accepted request.
//  FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | RESP) -> IDLE.
//   IDLE : accept. If m==0, go straight to RESP: ack, dat=0, no downstream cycle.
//   ISSUE: lane L = lowest set bit of m. Drive cyc=stb=1, we=latched we, sel=sel[4L+3:4L],
//          padr={padr[31:4],L[1:0],2'b00}, vadr adjusted the same way, dat=data1[32L+31:32L],
//          sz=tetra, cti=classic, blen=0. All other fields (om,cmd,cid,tid,asid,pl,pri,cache,seg,csr)
//          are copied from the latched request. Next state WAIT.
//   WAIT : req32_o held stable while resp32_i.stall=1. On resp32_i.ack with matching tid:
//          on a read, capture resp32_i.dat into rdbuf[32L+31:32L]; clear m[L]; drop cyc/stb for
//          one cycle; go to ISSUE if m!=0, else RESP.
//          On resp32_i.err, or timeout counter reaching TIMEOUT: drop the beat, set errflag, go to RESP
//          (remaining lanes are abandoned).
//          On resp32_i.rty: if retry counter < MAX_RETRY, increment it and go to ISSUE for the same
//          lane; else set errflag and go to RESP.
//          If ack and err arrive in the same cycle, err wins.
//   RESP : for exactly one cycle drive resp128_o.ack=!errflag, err=errflag, dat=rdbuf
//          (lanes not read are 0), cid/tid/pri/adr taken from the latched request. Then IDLE.
//  The retry counter clears on each new lane. The timeout counter clears on entry to WAIT.
//  Overall latency = 1 accept + per beat (1 issue + slave latency + 1 turnaround) + 1 response.
//  Writes also complete with ack; rdbuf is don't-care on writes and is driven to 0.
//  An ack whose tid does not match is ignored (no state change; the timeout counter keeps running).
//  rst_i during any state aborts immediately: outputs return to reset values on the next edge and
//   no upstream response is generated.
// STRUCTURE
//  fta_bus_pkg : add typedef fta_split_state_t {IDLE,ISSUE,WAIT,RESP}, and localparams
//   FTA_LANES128_32=4 and FTA_SPLIT_TOCNT_W=$clog2(TIMEOUT+1) as a default.
//  Sub-module fta_lane_pick: combinational 4-bit lowest-set-bit encoder giving lane[1:0] and valid.
// TESTING
//  1 Read sel=16'hFFFF, padr=32'h1000: beats at padr 1000/1004/1008/100C; slave returns
//    11111111/22222222/33333333/44444444 -> one ack, dat=128'h44444444_33333333_22222222_11111111.
//  2 Write sel=16'h0F0F, data1=128'hDDDD..._AAAA_AAAA: exactly 2 beats (padr x0 dat AAAAAAAA,
//    padr x8 dat CCCCCCCC), each with sel=4'hF -> ack.
//  3 Read sel=16'h00F0; slave answers rty twice, then ack 5A5A5A5A -> 3 issues of padr x4,
//    ack with dat[63:32]=5A5A5A5A and all other bits 0.
//  4 sel=16'hFFFF; slave answers err on beat 2 -> beats 3/4 never issued; resp128_o.err=1, ack=0.
//  5 No slave response: timeout fires after TIMEOUT cycles -> err; sel=0 request -> ack next cycle,
//    no req32_o.cyc.
//  6 Assert rst_i while in WAIT -> next cycle req32_o.cyc=0, busy_o=0, no resp128_o ack/err pulse;
//    the following request then completes normally.

Source files
------------

// File: rtl/fta_bus_pkg.sv
// Bus types and constants for the 128->32 FTA splitter.
package fta_bus_pkg;

   localparam int         FTA_TIMEOUT_DEF   = 1023;
   localparam int         FTA_LANES128_32   = 4;
   localparam int         FTA_SPLIT_TOCNT_W = $clog2(FTA_TIMEOUT_DEF + 1);
   localparam logic [3:0] FTA_SZ_TETRA      = 4'd2;
   localparam logic [2:0] FTA_CTI_CLASSIC   = 3'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } fta_split_state_t;

   typedef struct packed {
      logic [1:0]   om;
      logic [4:0]   cmd;
      logic [3:0]   cid;
      logic [7:0]   tid;
      logic [7:0]   asid;
      logic [1:0]   pl;
      logic [3:0]   pri;
      logic [3:0]   cache;
      logic [2:0]   seg;
      logic         csr;
      logic [2:0]   bte;
      logic [2:0]   cti;
      logic [5:0]   blen;
      logic [3:0]   sz;
      logic         cyc;
      logic         stb;
      logic         we;
      logic [31:0]  vadr;
      logic [31:0]  padr;
      logic [15:0]  sel;
      logic [127:0] data1;
   } fta_cmd_request128_t;

   typedef struct packed {
      logic [1:0]   om;
      logic [4:0]   cmd;
      logic [3:0]   cid;
      logic [7:0]   tid;
      logic [7:0]   asid;
      logic [1:0]   pl;
      logic [3:0]   pri;
      logic [3:0]   cache;
      logic [2:0]   seg;
      logic         csr;
      logic [2:0]   bte;
      logic [2:0]   cti;
      logic [5:0]   blen;
      logic [3:0]   sz;
      logic         cyc;
      logic         stb;
      logic         we;
      logic [31:0]  vadr;
      logic [31:0]  padr;
      logic [3:0]   sel;
      logic [31:0]  data1;
   } fta_cmd_request32_t;

   typedef struct packed {
      logic [3:0]   cid;
      logic [7:0]   tid;
      logic [3:0]   pri;
      logic         stall;
      logic         next;
      logic         ack;
      logic         rty;
      logic         err;
      logic [31:0]  adr;
      logic [127:0] dat;
   } fta_cmd_response128_t;

   typedef struct packed {
      logic [3:0]   cid;
      logic [7:0]   tid;
      logic [3:0]   pri;
      logic         stall;
      logic         next;
      logic         ack;
      logic         rty;
      logic         err;
      logic [31:0]  adr;
      logic [31:0]  dat;
   } fta_cmd_response32_t;

endpackage

// File: rtl/fta_lane_pick.sv
// Lowest-set-bit encoder over the four 32-bit lane flags.
module fta_lane_pick (
   input  logic [3:0] i_mask,
   output logic [1:0] o_lane,
   output logic       o_valid
);

   // Priority encode: lane 0 has the highest priority so beats go out in ascending order.
   always_comb begin
      o_lane  = 2'd0;
      o_valid = 1'b1;
      if (i_mask[0])      o_lane = 2'd0;
      else if (i_mask[1]) o_lane = 2'd1;
      else if (i_mask[2]) o_lane = 2'd2;
      else if (i_mask[3]) o_lane = 2'd3;
      else                o_valid = 1'b0;
   end

endmodule

// File: rtl/fta_split128to32.sv
// Sequential 128->32 FTA adapter: one 128-bit request becomes one 32-bit beat per
// active lane, and the beat responses are merged into a single 128-bit response.
//
// Handshake: upstream presents cyc&stb; the request is taken in the IDLE cycle and
// resp128_o.stall stays high until the one-cycle ack/err pulse in RESP. Downstream,
// req32_o.cyc/stb are high only in WAIT; they drop for at least one ISSUE cycle
// between beats, so every rising cyc is a new beat.
module fta_split128to32
   import fta_bus_pkg::*;
#(
   parameter int TIMEOUT   = 1023,
   parameter int MAX_RETRY = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  fta_cmd_request128_t  req128_i,
   output fta_cmd_response128_t resp128_o,
   output fta_cmd_request32_t   req32_o,
   input  fta_cmd_response32_t  resp32_i,
   output logic                 busy_o
);

   localparam int TOCNT_W = $clog2(TIMEOUT + 1);
   localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   fta_split_state_t    r_state;
   fta_cmd_request128_t r_req;
   fta_cmd_request32_t  r_req32;
   logic [3:0]          r_mask;
   logic [1:0]          r_lane;
   logic [127:0]        r_rdbuf;
   logic                r_err;
   logic [TOCNT_W-1:0]  r_tocnt;
   logic [RTY_W-1:0]    r_rtycnt;

   logic [3:0]          w_mask_in;
   logic [3:0]          w_mask_next;
   logic [1:0]          w_lane;
   logic                w_valid;
   logic                w_ack_ok;
   fta_cmd_request32_t  w_beat;
   logic                w_unused;

   fta_lane_pick u_lane_pick (
      .i_mask  (r_mask),
      .o_lane  (w_lane),
      .o_valid (w_valid)
   );

   // Lane flags of the incoming request: a lane is active when any of its byte selects is set.
   always_comb begin
      w_mask_in = 4'd0;
      for (int i = 0; i < FTA_LANES128_32; i++) begin
         w_mask_in[i] = |req128_i.sel[4*i +: 4];
      end
   end

   // Beat for the lowest active lane, built from the latched request.
   always_comb begin
      w_beat       = '0;
      w_beat.om    = r_req.om;
      w_beat.cmd   = r_req.cmd;
      w_beat.cid   = r_req.cid;
      w_beat.tid   = r_req.tid;
      w_beat.asid  = r_req.asid;
      w_beat.pl    = r_req.pl;
      w_beat.pri   = r_req.pri;
      w_beat.cache = r_req.cache;
      w_beat.seg   = r_req.seg;
      w_beat.csr   = r_req.csr;
      w_beat.bte   = r_req.bte;
      w_beat.cti   = FTA_CTI_CLASSIC;
      w_beat.blen  = 6'd0;
      w_beat.sz    = FTA_SZ_TETRA;
      w_beat.cyc   = 1'b1;
      w_beat.stb   = 1'b1;
      w_beat.we    = r_req.we;
      w_beat.vadr  = {r_req.vadr[31:4], w_lane, 2'b00};
      w_beat.padr  = {r_req.padr[31:4], w_lane, 2'b00};
      w_beat.sel   = r_req.sel[{w_lane, 2'b00} +: 4];
      w_beat.data1 = r_req.data1[{w_lane, 5'd0} +: 32];
   end

   // Lane bookkeeping for the beat in flight; stray acks from other transactions are ignored.
   always_comb begin
      w_mask_next = r_mask & ~(4'b0001 << r_lane);
      w_ack_ok    = resp32_i.ack && (resp32_i.tid == r_req32.tid);
   end

   // Main sequencer: accept, issue beats, collect responses, report once.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_req    <= '0;
         r_req32  <= '0;
         r_mask   <= 4'd0;
         r_lane   <= 2'd0;
         r_rdbuf  <= '0;
         r_err    <= 1'b0;
         r_tocnt  <= '0;
         r_rtycnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req128_i.cyc && req128_i.stb) begin
                  r_req    <= req128_i;
                  r_mask   <= w_mask_in;
                  r_rdbuf  <= '0;
                  r_err    <= 1'b0;
                  r_rtycnt <= '0;
                  r_tocnt  <= '0;
                  r_state  <= (w_mask_in == 4'd0) ? RESP : ISSUE;
               end
            end
            ISSUE: begin
               if (w_valid) begin
                  r_req32 <= w_beat;
                  r_lane  <= w_lane;
                  r_tocnt <= '0;
                  r_state <= WAIT;
               end else begin
                  r_state <= RESP;
               end
            end
            WAIT: begin
               if (resp32_i.err) begin
                  r_req32.cyc <= 1'b0;
                  r_req32.stb <= 1'b0;
                  r_err       <= 1'b1;
                  r_state     <= RESP;
               end else if (w_ack_ok) begin
                  if (!r_req.we) begin
                     r_rdbuf[{r_lane, 5'd0} +: 32] <= resp32_i.dat;
                  end
                  r_mask      <= w_mask_next;
                  r_rtycnt    <= '0;
                  r_req32.cyc <= 1'b0;
                  r_req32.stb <= 1'b0;
                  r_state     <= (w_mask_next != 4'd0) ? ISSUE : RESP;
               end else if (resp32_i.rty) begin
                  r_req32.cyc <= 1'b0;
                  r_req32.stb <= 1'b0;
                  if (r_rtycnt < RTY_W'(MAX_RETRY)) begin
                     r_rtycnt <= r_rtycnt + 1'b1;
                     r_state  <= ISSUE;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= RESP;
                  end
               end else if (r_tocnt == TOCNT_W'(TIMEOUT)) begin
                  r_req32.cyc <= 1'b0;
                  r_req32.stb <= 1'b0;
                  r_err       <= 1'b1;
                  r_state     <= RESP;
               end else begin
                  r_tocnt <= r_tocnt + 1'b1;
               end
            end
            RESP: begin
               r_req32 <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Upstream response: stall while busy, one ack/err pulse in RESP.
   always_comb begin
      resp128_o       = '0;
      resp128_o.stall = (r_state != IDLE);
      if (r_state == RESP) begin
         resp128_o.ack = !r_err;
         resp128_o.err = r_err;
         resp128_o.dat = r_rdbuf;
         resp128_o.cid = r_req.cid;
         resp128_o.tid = r_req.tid;
         resp128_o.pri = r_req.pri;
         resp128_o.adr = r_req.padr;
      end
   end

   assign req32_o = r_req32;
   assign busy_o  = (r_state != IDLE);

   // Fields that the splitter deliberately does not use.
   assign w_unused = ^{r_req.cyc, r_req.stb, r_req.cti, r_req.blen, r_req.sz, r_req.vadr[3:0],
                       resp32_i.cid, resp32_i.pri, resp32_i.stall, resp32_i.next, resp32_i.adr};

endmodule

// File: tb/tb_fta_split128to32.sv
// Self-checking bench for fta_split128to32: directed cases plus random transactions,
// each checked against a lane-by-lane transaction model and a scripted 32-bit slave.
module tb_fta_split128to32;
  import fta_bus_pkg::*;

  localparam int TIMEOUT   = 1023;
  localparam int MAX_RETRY = 3;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_RTY  = 2;
  localparam int K_NONE = 3;

  typedef struct {
    int          kind;
    int          lat;
    logic [31:0] dat;
    bit          bad;
  } slv_t;

  typedef struct packed {
    logic [31:0] padr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic [7:0]  tid;
    logic [3:0]  sz;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  fta_cmd_request128_t  req128;
  fta_cmd_response128_t resp128;
  fta_cmd_request32_t   req32;
  fta_cmd_response32_t  resp32;
  logic                 busy;

  slv_t  script_q[$];
  beat_t obs_q[$];
  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  fta_split128to32 #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req128_i  (req128),
    .resp128_o (resp128),
    .req32_o   (req32),
    .resp32_i  (resp32),
    .busy_o    (busy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scripted slave: records every beat, answers per script entry
  bit   sl_act = 1'b0;
  int   sl_t   = 0;
  slv_t sl_cur;
  logic sl_prev = 1'b0;

  initial begin
    resp32 = '0;
    forever begin
      @(negedge clk);
      resp32 = '0;
      if (rst) begin
        sl_act  = 1'b0;
        sl_prev = 1'b0;
      end else begin
        if (req32.cyc && req32.stb && !sl_prev) begin
          obs_q.push_back({req32.padr, req32.sel, req32.we, req32.data1, req32.tid, req32.sz});
          if (script_q.size() > 0) sl_cur = script_q.pop_front();
          else begin
            sl_cur.kind = K_NONE; sl_cur.lat = 0; sl_cur.dat = 32'd0; sl_cur.bad = 1'b0;
          end
          sl_act = 1'b1;
          sl_t   = 0;
        end
        sl_prev = req32.cyc;
        if (sl_act && req32.cyc) begin
          if (sl_cur.bad && sl_t == sl_cur.lat) begin
            resp32.ack = 1'b1;
            resp32.tid = req32.tid ^ 8'h5A;
            resp32.dat = 32'hBADBAD00;
          end else if (sl_t == sl_cur.lat + (sl_cur.bad ? 2 : 0)) begin
            case (sl_cur.kind)
              K_ACK: begin resp32.ack = 1'b1; resp32.tid = req32.tid; resp32.dat = sl_cur.dat; end
              K_ERR: begin resp32.err = 1'b1; resp32.tid = req32.tid; resp32.dat = 32'hEEEE0001; end
              K_RTY: begin resp32.rty = 1'b1; resp32.tid = req32.tid; resp32.dat = 32'hEEEE0002; end
              default: ;
            endcase
            if (sl_cur.kind != K_NONE) sl_act = 1'b0;
          end
          sl_t++;
        end else if (!req32.cyc) begin
          sl_act = 1'b0;
        end
      end
    end
  end

  function automatic slv_t mk(input int kind, input int lat, input logic [31:0] dat, input bit bad);
    slv_t s;
    s.kind = kind; s.lat = lat; s.dat = dat; s.bad = bad;
    return s;
  endfunction

  // Transaction model: walk active lanes in ascending order, consume slave answers,
  // and predict the beats, the final ack/err, merged read data and total latency
  // (negedges from presenting the request to seeing the response).
  task automatic model(input logic [15:0] sel, input logic we, input logic [31:0] padr,
                       input logic [127:0] data, input logic [7:0] tid,
                       output logic e_ack, output logic [127:0] e_dat, output int e_lat);
    slv_t  sc[$];
    slv_t  s;
    beat_t b;
    int    tries;
    bit    stop;
    bit    adv;
    sc = script_q;
    exp_q.delete();
    e_ack = 1'b1;
    e_dat = '0;
    e_lat = 1;
    stop  = 1'b0;
    for (int ln = 0; ln < 4; ln++) begin
      if (!stop && sel[ln*4 +: 4] != 4'd0) begin
        tries = 0;
        adv   = 1'b0;
        while (!adv && !stop) begin
          if (sc.size() > 0) s = sc.pop_front();
          else s = mk(K_NONE, 0, 32'd0, 1'b0);
          b.padr = {padr[31:4], 2'(ln), 2'b00};
          b.sel  = sel[ln*4 +: 4];
          b.we   = we;
          b.dat  = data[ln*32 +: 32];
          b.tid  = tid;
          b.sz   = FTA_SZ_TETRA;
          exp_q.push_back(b);
          if (s.kind == K_NONE) begin
            e_lat += 2 + TIMEOUT;
            e_ack  = 1'b0;
            stop   = 1'b1;
          end else begin
            e_lat += 2 + s.lat + (s.bad ? 2 : 0);
            if (s.kind == K_ACK) begin
              if (!we) e_dat[ln*32 +: 32] = s.dat;
              adv = 1'b1;
            end else if (s.kind == K_ERR) begin
              e_ack = 1'b0;
              stop  = 1'b1;
            end else if (tries < MAX_RETRY) begin
              tries++;
            end else begin
              e_ack = 1'b0;
              stop  = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // driver: present one request, wait (bounded) for its response, check everything
  task automatic run_txn(input string tag, input logic [15:0] sel, input logic we,
                         input logic [31:0] padr, input logic [127:0] data,
                         input logic [7:0] tid, output logic [127:0] o_dat);
    logic         e_ack;
    logic [127:0] e_dat;
    int           e_lat;
    int           lat;
    bit           got;
    logic [3:0]   cid;
    logic [3:0]   pri;
    int           nb;
    model(sel, we, padr, data, tid, e_ack, e_dat, e_lat);
    obs_q.delete();
    cid = 4'($urandom);
    pri = 4'($urandom);
    @(negedge clk);
    req128       = '0;
    req128.cyc   = 1'b1;
    req128.stb   = 1'b1;
    req128.we    = we;
    req128.sel   = sel;
    req128.padr  = padr;
    req128.vadr  = padr ^ 32'h8000_0000;
    req128.data1 = data;
    req128.tid   = tid;
    req128.cid   = cid;
    req128.pri   = pri;
    req128.om    = 2'($urandom);
    @(negedge clk);
    req128.cyc = 1'b0;
    req128.stb = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 20000) begin
      if (resp128.ack || resp128.err) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    o_dat = resp128.dat;
    check({tag, "/done"}, 256'(got), 256'(1'b1));
    check({tag, "/ack"},  256'(resp128.ack), 256'(e_ack));
    check({tag, "/err"},  256'(resp128.err), 256'(!e_ack));
    check({tag, "/dat"},  256'(resp128.dat), 256'(e_dat));
    check({tag, "/ids"},  256'({resp128.tid, resp128.cid, resp128.pri, resp128.adr}),
                          256'({tid, cid, pri, padr}));
    check({tag, "/lat"},  256'(lat), 256'(e_lat));
    @(negedge clk);
    check({tag, "/pulse"}, 256'({resp128.ack, resp128.err, busy}), 256'(3'b000));
    check({tag, "/nbeats"}, 256'(obs_q.size()), 256'(exp_q.size()));
    nb = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++) begin
      check({tag, "/beat"}, 256'(obs_q[i]), 256'(exp_q[i]));
    end
    script_q.delete();
  endtask

  logic [127:0] r_dat;
  int           pulses;

  initial begin
    req128 = '0;
    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst/req32",  256'(req32),   256'(0));
    check("rst/resp128", 256'(resp128), 256'(0));
    check("rst/busy",   256'(busy),    256'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    // 1: full-width read, four beats
    for (int i = 0; i < 4; i++) script_q.push_back(mk(K_ACK, i, {8{4'(i + 1)}}, 1'b0));
    run_txn("rd_full", 16'hFFFF, 1'b0, 32'h0000_1000, 128'h0, 8'h11, r_dat);
    check("rd_full/const", 256'(r_dat), 256'(128'h44444444_33333333_22222222_11111111));

    // 2: sparse write, lanes 0 and 2 only
    for (int i = 0; i < 2; i++) script_q.push_back(mk(K_ACK, 1, 32'h0, 1'b0));
    run_txn("wr_sparse", 16'h0F0F, 1'b1, 32'h0000_2000,
            128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 8'h22, r_dat);
    check("wr_sparse/dat0", 256'(r_dat), 256'(0));

    // 3: two retries then ack on lane 1
    script_q.push_back(mk(K_RTY, 0, 32'h0, 1'b0));
    script_q.push_back(mk(K_RTY, 2, 32'h0, 1'b0));
    script_q.push_back(mk(K_ACK, 0, 32'h5A5A5A5A, 1'b0));
    run_txn("rty2", 16'h00F0, 1'b0, 32'h0000_3000, 128'h0, 8'h33, r_dat);
    check("rty2/const", 256'(r_dat), 256'(128'h00000000_00000000_5A5A5A5A_00000000));

    // retry limit: MAX_RETRY+1 rty answers fail the transaction
    for (int i = 0; i <= MAX_RETRY; i++) script_q.push_back(mk(K_RTY, 0, 32'h0, 1'b0));
    run_txn("rty_lim", 16'h000F, 1'b0, 32'h0000_3100, 128'h0, 8'h34, r_dat);

    // 4: err on beat 2 abandons beats 3/4
    script_q.push_back(mk(K_ACK, 0, 32'h12345678, 1'b0));
    script_q.push_back(mk(K_ERR, 1, 32'h0, 1'b0));
    script_q.push_back(mk(K_ACK, 0, 32'h0, 1'b0));
    script_q.push_back(mk(K_ACK, 0, 32'h0, 1'b0));
    run_txn("err_b2", 16'hFFFF, 1'b0, 32'h0000_4000, 128'h0, 8'h44, r_dat);

    // wrong-tid ack is ignored, the real ack completes the beat
    script_q.push_back(mk(K_ACK, 1, 32'hCAFEF00D, 1'b1));
    run_txn("bad_tid", 16'h3000, 1'b0, 32'h0000_4800, 128'h0, 8'h48, r_dat);

    // 5: silent slave -> timeout err; empty sel -> immediate ack
    script_q.push_back(mk(K_NONE, 0, 32'h0, 1'b0));
    run_txn("timeout", 16'h0F00, 1'b0, 32'h0000_5000, 128'h0, 8'h55, r_dat);
    run_txn("sel0", 16'h0000, 1'b1, 32'h0000_5100, 128'h1, 8'h56, r_dat);

    // 6: reset while waiting on a beat
    script_q.push_back(mk(K_NONE, 0, 32'h0, 1'b0));
    @(negedge clk);
    req128      = '0;
    req128.cyc  = 1'b1;
    req128.stb  = 1'b1;
    req128.sel  = 16'h00FF;
    req128.padr = 32'h0000_6000;
    req128.tid  = 8'h66;
    @(negedge clk);
    req128.cyc = 1'b0;
    req128.stb = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_wait/pre", 256'({busy, req32.cyc, resp128.stall}), 256'(3'b111));
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait/post", 256'({req32.cyc, busy, resp128.ack, resp128.err}), 256'(4'b0000));
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp128.ack || resp128.err) pulses++;
    end
    check("rst_wait/nopulse", 256'(pulses), 256'(0));
    script_q.delete();
    obs_q.delete();
    for (int i = 0; i < 2; i++) script_q.push_back(mk(K_ACK, 0, 32'h7700_0000 + 32'(i), 1'b0));
    run_txn("after_rst", 16'hF00F, 1'b0, 32'h0000_6100, 128'h0, 8'h67, r_dat);

    // random transactions
    for (int t = 0; t < 24; t++) begin
      int r;
      logic [15:0] sel;
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 19);
        script_q.push_back(mk((r < 15) ? K_ACK : ((r < 18) ? K_RTY : K_ERR),
                              $urandom_range(0, 3), $urandom, ($urandom_range(0, 9) == 0)));
      end
      r = $urandom_range(0, 9);
      sel = (r == 0) ? 16'h0000 : ((r == 1) ? 16'hFFFF : 16'($urandom));
      run_txn("rand", sel, 1'($urandom), {$urandom} & 32'hFFFF_FFF0,
              {$urandom, $urandom, $urandom, $urandom}, 8'($urandom), r_dat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
